instr_compressor: RTL



---
 rtl/compress_pkg.sv | 22 ++
 rtl/instr_compressor_if.sv | 16 +
 rtl/pair_cam.sv | 32 +++
 rtl/instr_compressor.sv | 77 +++++++
 4 files changed

// File: rtl/compress_pkg.sv
// compress_pkg: shared sizes, FSM/table types and token builder for instr_compressor.
package compress_pkg;
  localparam int WIDTH = 32;
  localparam int ENCODE_LEN = 4;
  localparam logic [ENCODE_LEN-1:0] OPCODE = 4'b1111;
  localparam int ENTRIES = 16;
  localparam int CNT_W = 16;
  localparam int IDX_W = $clog2(ENTRIES);
  typedef enum logic {PEND_EMPTY, PEND_FULL} pend_state_t;
  typedef struct packed {
    logic valid;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] second;
  } pair_entry_t;
  // Entry i lives at byte address i*8 in the decompressor's table.
  function automatic logic [WIDTH-1:0] make_token(input logic [IDX_W-1:0] idx);
    return {OPCODE, {(WIDTH-ENCODE_LEN-IDX_W-3){1'b0}}, idx, 3'b000};
  endfunction
  function automatic logic is_escape(input logic [WIDTH-1:0] w);
    return w[WIDTH-1 -: ENCODE_LEN] == OPCODE;
  endfunction
endpackage

// File: rtl/instr_compressor_if.sv
// instr_compressor_if: instruction streams, table write port and status of the compressor.
interface instr_compressor_if;
  import compress_pkg::*;
  logic in_valid, in_ready, flush, out_valid, out_ready, wme, wr_en_bit, esc_err;
  logic [WIDTH-1:0] in_instr, out_instr, wr_first, wr_second;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] tok_count;
  modport master (
    output in_valid, in_instr, flush, out_ready, wme, wr_idx, wr_en_bit, wr_first, wr_second,
    input  in_ready, out_valid, out_instr, esc_err, tok_count
  );
  modport slave (
    input  in_valid, in_instr, flush, out_ready, wme, wr_idx, wr_en_bit, wr_first, wr_second,
    output in_ready, out_valid, out_instr, esc_err, tok_count
  );
endinterface

// File: rtl/pair_cam.sv
// pair_cam: pair table with one write port and parallel first/pair compare, lowest index wins.
module pair_cam
  import compress_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  pair_entry_t      i_wr_entry,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_first_hit_any,
  output logic             o_pair_hit,
  output logic [IDX_W-1:0] o_pair_idx
);
  pair_entry_t r_tab [ENTRIES];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < ENTRIES; k++) r_tab[k] <= '0;
    else if (i_we) r_tab[i_wr_idx] <= i_wr_entry;
  always_comb begin
    o_first_hit_any = 1'b0;
    o_pair_hit = 1'b0;
    o_pair_idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (r_tab[k].valid && r_tab[k].first == i_p) o_first_hit_any = 1'b1;
      if (r_tab[k].valid && r_tab[k].first == i_p && r_tab[k].second == i_y) begin
        o_pair_hit = 1'b1;
        o_pair_idx = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/instr_compressor.sv
// instr_compressor: replaces adjacent instruction pairs found in the pair table with token words.
module instr_compressor
  import compress_pkg::*;
(
  input logic clk,
  input logic reset,
  instr_compressor_if.slave bus
);
  pend_state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_pend, r_out_instr, w_word;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_pair_idx;
  logic r_out_valid, w_slot, w_acc, w_emit, w_load, w_tok, w_cand, w_hit, w_first_hit, w_pair_hit;
  pair_entry_t w_wr_entry;

  assign w_wr_entry = '{valid: bus.wr_en_bit, first: bus.wr_first, second: bus.wr_second};

  pair_cam u_cam (
    .clk(clk), .rst(reset), .i_we(bus.wme), .i_wr_idx(bus.wr_idx), .i_wr_entry(w_wr_entry),
    .i_p(r_pend), .i_y(bus.in_instr),
    .o_first_hit_any(w_first_hit), .o_pair_hit(w_pair_hit), .o_pair_idx(w_pair_idx)
  );

  assign w_slot = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !reset && w_slot && !(bus.flush && r_state == PEND_FULL);
  assign w_acc = bus.in_valid && bus.in_ready;
  // Escape words are never part of a pair on either side.
  assign w_cand = w_first_hit && !is_escape(r_pend);
  assign w_hit = w_pair_hit && !is_escape(r_pend) && !is_escape(bus.in_instr);
  assign bus.esc_err = w_acc && is_escape(bus.in_instr);
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.tok_count = r_cnt;

  always_comb begin
    w_state_nx = r_state;
    w_emit = 1'b0;
    w_word = r_pend;
    w_load = 1'b0;
    w_tok = 1'b0;
    if (r_state == PEND_EMPTY) begin
      w_load = w_acc;
      w_state_nx = w_acc ? PEND_FULL : PEND_EMPTY;
    end else if (bus.flush && w_slot) begin
      w_emit = 1'b1;
      w_state_nx = PEND_EMPTY;
    end else if (w_acc && w_hit) begin
      w_emit = 1'b1;
      w_word = make_token(w_pair_idx);
      w_tok = 1'b1;
      w_state_nx = PEND_EMPTY;
    end else if (w_acc) begin
      w_emit = 1'b1;
      w_load = 1'b1;
    end else if (!w_cand && w_slot) begin
      w_emit = 1'b1;
      w_state_nx = PEND_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= PEND_EMPTY;
    else r_state <= w_state_nx;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pend <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_load) r_pend <= bus.in_instr;
      if (w_slot) r_out_valid <= w_emit;
      if (w_slot && w_emit) r_out_instr <= w_word;
      if (w_tok && ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule
